// File: rtl/button_pkg.sv
// Shared types and constant helpers for the multi-channel pushbutton event generator.
package button_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHORT = 2'd1,
        LONG  = 2'd2
    } btn_state_e;

    // Clock cycles per 1 ms tick.
    function automatic int tick_div(input int clk_hz);
        return clk_hz / 1000;
    endfunction

    // Bits needed to hold 0..max_val, never less than one.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/ms_tick.sv
// Shared millisecond prescaler: one-cycle tick every TICK_DIV clocks.
module ms_tick
    import button_pkg::*;
#(
    parameter int TICK_DIV = 50_000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int            CW   = cnt_width(TICK_DIV - 1);
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_r;

    // Free-running 0..TICK_DIV-1 counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= '0;
        end else if (cnt_r == LAST) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_r + 1'b1;
        end
    end

    assign tick = (cnt_r == LAST);

endmodule

// File: rtl/button_events.sv
// Per-channel synchronise, debounce and classify pushbuttons into held level,
// click, long-press and auto-repeat pulses, all timed off one shared 1 ms tick.
module button_events
    import button_pkg::*;
#(
    parameter int N_BTN       = 4,
    parameter int CLK_HZ      = 50_000_000,
    parameter int DEBOUNCE_MS = 20,
    parameter int LONG_MS     = 500,
    parameter int REPEAT_MS   = 200,
    parameter bit ACTIVE_LOW  = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_BTN-1:0] raw,
    output logic [N_BTN-1:0] held,
    output logic [N_BTN-1:0] click,
    output logic [N_BTN-1:0] long_press,
    output logic [N_BTN-1:0] rpt
);

    localparam int TICK_DIV = tick_div(CLK_HZ);

    localparam int DB_MAX   = DEBOUNCE_MS - 1;
    localparam int HOLD_MAX = LONG_MS - DEBOUNCE_MS - 1;
    localparam int REP_MAX  = (REPEAT_MS > 0) ? (REPEAT_MS - 1) : 0;

    localparam int DBW = cnt_width(DB_MAX);
    localparam int HW  = cnt_width(HOLD_MAX);
    localparam int RW  = cnt_width(REP_MAX);

    localparam logic [DBW-1:0] DB_LAST   = DBW'(DB_MAX);
    localparam logic [HW-1:0]  HOLD_LAST = HW'(HOLD_MAX);
    localparam logic [RW-1:0]  REP_LAST  = RW'(REP_MAX);

    logic             tick_s;
    logic [N_BTN-1:0] pressed_s;

    assign pressed_s = raw ^ {N_BTN{ACTIVE_LOW}};

    ms_tick #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick_s)
    );

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        logic           sync1_r;
        logic           sync2_r;
        logic           held_r;
        logic           held_nxt_s;
        logic           rise_s;
        logic           fall_s;
        logic [DBW-1:0] db_ms_r;
        logic [DBW-1:0] db_ms_nxt_s;
        btn_state_e     state_r;
        btn_state_e     state_nxt_s;
        logic [HW-1:0]  hold_ms_r;
        logic [HW-1:0]  hold_ms_nxt_s;
        logic [RW-1:0]  rep_ms_r;
        logic [RW-1:0]  rep_ms_nxt_s;
        logic           click_nxt_s;
        logic           long_nxt_s;
        logic           rpt_nxt_s;
        logic           click_r;
        logic           long_r;
        logic           rpt_r;

        // Debounce: accept a level change only after DEBOUNCE_MS stable ticks
        always_comb begin
            held_nxt_s  = held_r;
            db_ms_nxt_s = db_ms_r;
            if (sync2_r == held_r) begin
                db_ms_nxt_s = '0;
            end else if (tick_s) begin
                if (db_ms_r == DB_LAST) begin
                    held_nxt_s  = ~held_r;
                    db_ms_nxt_s = '0;
                end else begin
                    db_ms_nxt_s = db_ms_r + 1'b1;
                end
            end else begin
                db_ms_nxt_s = db_ms_r;
            end
        end

        // Edges come from the next held value so click lands with the held fall
        assign rise_s = ~held_r & held_nxt_s;
        assign fall_s = held_r & ~held_nxt_s;

        // Event FSM: IDLE -> SHORT on press; SHORT -> LONG at hold limit
        always_comb begin
            state_nxt_s   = state_r;
            hold_ms_nxt_s = hold_ms_r;
            rep_ms_nxt_s  = rep_ms_r;
            click_nxt_s   = 1'b0;
            long_nxt_s    = 1'b0;
            rpt_nxt_s     = 1'b0;
            case (state_r)
                IDLE: begin
                    if (rise_s) begin
                        state_nxt_s   = SHORT;
                        hold_ms_nxt_s = '0;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end
                SHORT: begin
                    // A release on the long-press tick wins and yields a click
                    if (fall_s) begin
                        click_nxt_s = 1'b1;
                        state_nxt_s = IDLE;
                    end else if (tick_s) begin
                        if (hold_ms_r == HOLD_LAST) begin
                            long_nxt_s   = 1'b1;
                            state_nxt_s  = LONG;
                            rep_ms_nxt_s = '0;
                        end else begin
                            hold_ms_nxt_s = hold_ms_r + 1'b1;
                        end
                    end else begin
                        hold_ms_nxt_s = hold_ms_r;
                    end
                end
                LONG: begin
                    if (fall_s) begin
                        state_nxt_s = IDLE;
                    end else if ((REPEAT_MS > 0) && tick_s) begin
                        if (rep_ms_r == REP_LAST) begin
                            rpt_nxt_s    = 1'b1;
                            rep_ms_nxt_s = '0;
                        end else begin
                            rep_ms_nxt_s = rep_ms_r + 1'b1;
                        end
                    end else begin
                        rep_ms_nxt_s = rep_ms_r;
                    end
                end
                default: begin
                    state_nxt_s   = IDLE;
                    hold_ms_nxt_s = '0;
                    rep_ms_nxt_s  = '0;
                end
            endcase
        end

        // Channel registers: synchroniser, debounce, FSM and output pulses
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sync1_r   <= 1'b0;
                sync2_r   <= 1'b0;
                held_r    <= 1'b0;
                db_ms_r   <= '0;
                state_r   <= IDLE;
                hold_ms_r <= '0;
                rep_ms_r  <= '0;
                click_r   <= 1'b0;
                long_r    <= 1'b0;
                rpt_r     <= 1'b0;
            end else begin
                sync1_r   <= pressed_s[i];
                sync2_r   <= sync1_r;
                held_r    <= held_nxt_s;
                db_ms_r   <= db_ms_nxt_s;
                state_r   <= state_nxt_s;
                hold_ms_r <= hold_ms_nxt_s;
                rep_ms_r  <= rep_ms_nxt_s;
                click_r   <= click_nxt_s;
                long_r    <= long_nxt_s;
                rpt_r     <= rpt_nxt_s;
            end
        end

        assign held[i]       = held_r;
        assign click[i]      = click_r;
        assign long_press[i] = long_r;
        assign rpt[i]        = rpt_r;
    end

endmodule

// File: tb/tb_button_events.sv
// Directed bench for button_events: 1 ms = 10 clocks, debounce 3, long 10, repeat 4 (and 0).
module tb_button_events;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] raw = 4'hF;
    logic [3:0] raw_b = 4'hF;
    logic [3:0] held, click, long_press, rpt;
    logic [3:0] held_b, click_b, long_b, rpt_b;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    button_events #(
        .N_BTN(4), .CLK_HZ(10_000), .DEBOUNCE_MS(3), .LONG_MS(10), .REPEAT_MS(4), .ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .raw(raw),
        .held(held), .click(click), .long_press(long_press), .rpt(rpt)
    );

    button_events #(
        .N_BTN(4), .CLK_HZ(10_000), .DEBOUNCE_MS(3), .LONG_MS(10), .REPEAT_MS(0), .ACTIVE_LOW(1'b1)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .raw(raw_b),
        .held(held_b), .click(click_b), .long_press(long_b), .rpt(rpt_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Event monitor: cumulative counts and last-seen cycle of every event
    int   click_cnt[4] = '{default: 0};
    int   long_cnt[4]  = '{default: 0};
    int   rpt_cnt[4]   = '{default: 0};
    int   rise_cnt[4]  = '{default: 0};
    int   click_cyc[4] = '{default: 0};
    int   long_cyc[4]  = '{default: 0};
    int   rpt_cyc[4]   = '{default: 0};
    int   rise_cyc[4]  = '{default: 0};
    int   fall_cyc[4]  = '{default: 0};
    int   long_b_cnt = 0, rpt_b_cnt = 0, click_b_cnt = 0, long_b_cyc = 0;
    logic [3:0] prev_held = 4'h0, prev_click = 4'h0, prev_long = 4'h0, prev_rpt = 4'h0;
    bit   viol = 1'b0;

    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (held[i] && !prev_held[i]) begin
                rise_cnt[i] <= rise_cnt[i] + 1;
                rise_cyc[i] <= cyc;
            end
            if (!held[i] && prev_held[i]) fall_cyc[i] <= cyc;
            if (click[i]) begin
                click_cnt[i] <= click_cnt[i] + 1;
                click_cyc[i] <= cyc;
            end
            if (long_press[i]) begin
                long_cnt[i] <= long_cnt[i] + 1;
                long_cyc[i] <= cyc;
            end
            if (rpt[i]) begin
                rpt_cnt[i] <= rpt_cnt[i] + 1;
                rpt_cyc[i] <= cyc;
            end
            if ((int'(click[i]) + int'(long_press[i]) + int'(rpt[i])) > 1) viol <= 1'b1;
            if (click[i] && !(prev_held[i] && !held[i])) viol <= 1'b1;
            if ((click[i] && prev_click[i]) || (long_press[i] && prev_long[i]) ||
                (rpt[i] && prev_rpt[i])) viol <= 1'b1;
        end
        if (long_b[2]) begin
            long_b_cnt <= long_b_cnt + 1;
            long_b_cyc <= cyc;
        end
        if (rpt_b[2])   rpt_b_cnt   <= rpt_b_cnt + 1;
        if (click_b[2]) click_b_cnt <= click_b_cnt + 1;
        prev_held  <= held;
        prev_click <= click;
        prev_long  <= long_press;
        prev_rpt   <= rpt;
    end

    task automatic check(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Move to a negedge right after a tick has been consumed (phase 0 of the ms)
    task automatic align();
        @(negedge clk);
        while (cyc % 10 != 0) @(negedge clk);
    endtask

    int t0, r;
    int s_click0, s_long0, s_click1, s_long1, s_rise1, s_click2, s_long2, s_rpt2;
    int s_click3, s_long3, s_lb, s_rb, s_cb;

    initial begin
        repeat (5) @(negedge clk);
        check("reset_held",  int'(held),       0);
        check("reset_click", int'(click),      0);
        check("reset_long",  int'(long_press), 0);
        check("reset_rpt",   int'(rpt),        0);
        check("reset_held_b", int'(held_b),    0);
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b1;

        // Short press on ch0: 6 ms, clean release
        align();
        t0 = cyc; s_click0 = click_cnt[0]; s_long0 = long_cnt[0];
        raw[0] = 1'b0;
        repeat (60) @(negedge clk);
        raw[0] = 1'b1;
        repeat (40) @(negedge clk);
        check("ch0_rise_time",  rise_cyc[0] - t0, 30);
        check("ch0_fall_time",  fall_cyc[0] - t0, 90);
        check("ch0_click_time", click_cyc[0] - t0, 90);
        check("ch0_click_cnt",  click_cnt[0] - s_click0, 1);
        check("ch0_no_long",    long_cnt[0] - s_long0, 0);

        // Bouncing ch1: 1 ms toggles, settles pressed at +4 ms
        align();
        t0 = cyc; s_click1 = click_cnt[1]; s_long1 = long_cnt[1]; s_rise1 = rise_cnt[1];
        for (int k = 0; k < 5; k++) begin
            raw[1] = k[0];
            repeat (10) @(negedge clk);
        end
        raw[1] = 1'b0;
        repeat (50) @(negedge clk);
        check("ch1_rise_cnt",   rise_cnt[1] - s_rise1, 1);
        check("ch1_rise_time",  rise_cyc[1] - t0, 70);
        check("ch1_no_click",   click_cnt[1] - s_click1, 0);
        raw[1] = 1'b1;
        repeat (40) @(negedge clk);
        check("ch1_click_cnt",  click_cnt[1] - s_click1, 1);
        check("ch1_click_time", click_cyc[1] - t0, 130);
        check("ch1_no_long",    long_cnt[1] - s_long1, 0);

        // Long hold on ch2 (25 ms) on both builds; repeat continues until debounced release
        align();
        t0 = cyc; s_click2 = click_cnt[2]; s_long2 = long_cnt[2]; s_rpt2 = rpt_cnt[2];
        s_lb = long_b_cnt; s_rb = rpt_b_cnt; s_cb = click_b_cnt;
        raw[2] = 1'b0;
        raw_b[2] = 1'b0;
        repeat (145) @(negedge clk);
        check("ch2_long_time",  long_cyc[2] - t0, 100);
        check("ch2_rpt1_time",  rpt_cyc[2] - t0, 140);
        check("b_long_time",    long_b_cyc - t0, 100);
        repeat (105) @(negedge clk);
        raw[2] = 1'b1;
        raw_b[2] = 1'b1;
        repeat (50) @(negedge clk);
        check("ch2_long_cnt",   long_cnt[2] - s_long2, 1);
        check("ch2_rpt_cnt",    rpt_cnt[2] - s_rpt2, 4);
        check("ch2_rpt4_time",  rpt_cyc[2] - t0, 260);
        check("ch2_fall_time",  fall_cyc[2] - t0, 280);
        check("ch2_no_click",   click_cnt[2] - s_click2, 0);
        check("b_long_cnt",     long_b_cnt - s_lb, 1);
        check("b_rpt_cnt",      rpt_b_cnt - s_rb, 0);
        check("b_no_click",     click_b_cnt - s_cb, 0);

        // Simultaneous short presses on ch0 and ch3
        align();
        t0 = cyc; s_click0 = click_cnt[0]; s_click3 = click_cnt[3]; s_long3 = long_cnt[3];
        raw[0] = 1'b0;
        raw[3] = 1'b0;
        repeat (50) @(negedge clk);
        raw[0] = 1'b1;
        raw[3] = 1'b1;
        repeat (40) @(negedge clk);
        check("dual_click0_time", click_cyc[0] - t0, 80);
        check("dual_click3_time", click_cyc[3] - t0, 80);
        check("dual_click0_cnt",  click_cnt[0] - s_click0, 1);
        check("dual_click3_cnt",  click_cnt[3] - s_click3, 1);
        check("dual_no_long3",    long_cnt[3] - s_long3, 0);

        // Reset in the middle of a ch1 hold; button stays pressed through reset
        align();
        t0 = cyc;
        raw[1] = 1'b0;
        repeat (60) @(negedge clk);
        check("rst_pre_held1", int'(held[1]), 1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_held",  int'(held),       0);
        check("rst_mid_click", int'(click),      0);
        check("rst_mid_long",  int'(long_press), 0);
        check("rst_mid_rpt",   int'(rpt),        0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        r = cyc; s_click1 = click_cnt[1]; s_long1 = long_cnt[1];
        repeat (50) @(negedge clk);
        raw[1] = 1'b1;
        repeat (40) @(negedge clk);
        check("rst_rise_time",  rise_cyc[1] - r, 30);
        check("rst_click_time", click_cyc[1] - r, 80);
        check("rst_click_cnt",  click_cnt[1] - s_click1, 1);
        check("rst_no_long",    long_cnt[1] - s_long1, 0);

        check("pulse_rules", int'(viol), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
